// File: rtl/mul_sched_pkg.sv
// Shared widths, operand-sign encoding and pipeline payload types for the
// shared-multiplier scheduler.
package mul_sched_pkg;
  localparam int XLEN = 32;
  localparam int PLEN = 64;
  localparam int NREQ = 2;
  localparam int BOOTH_DIGITS = XLEN / 2 + 1;

  localparam logic S_OR_US_SIGNED   = 1'b1;
  localparam logic S_OR_US_UNSIGNED = 1'b0;

  typedef struct packed {
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            s_or_us;
    logic            id;
  } iss_t;

  typedef struct packed {
    logic [PLEN-1:0] product;
    logic            id;
  } res_t;
endpackage

// File: rtl/booth_multiplier.sv
// Combinational radix-4 Booth multiplier, 32x32->64, signed or unsigned.
module booth_multiplier
  import mul_sched_pkg::*;
(
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic            s_or_us,
  output logic [PLEN-1:0] product
);
  logic [PLEN-1:0] mcand;
  logic [XLEN+2:0] mplier;
  logic [PLEN-1:0] pp [BOOTH_DIGITS];

  // Multiplier is widened by two extension bits so unsigned operands recode
  // as non-negative values; everything is then exact modulo 2^64.
  always_comb begin
    mcand  = (s_or_us == S_OR_US_SIGNED) ? {{(PLEN-XLEN){op1[XLEN-1]}}, op1}
                                         : {{(PLEN-XLEN){1'b0}}, op1};
    mplier = {(s_or_us == S_OR_US_UNSIGNED) ? 2'b00 : {2{op2[XLEN-1]}}, op2, 1'b0};
    for (int i = 0; i < BOOTH_DIGITS; i++) begin
      unique case (mplier[2*i +: 3])
        3'b001, 3'b010: pp[i] = mcand;
        3'b011:         pp[i] = mcand << 1;
        3'b100:         pp[i] = -(mcand << 1);
        3'b101, 3'b110: pp[i] = -mcand;
        default:        pp[i] = '0;
      endcase
      pp[i] = pp[i] << (2 * i);
    end
  end

  always_comb begin
    product = '0;
    for (int i = 0; i < BOOTH_DIGITS; i++) product = product + pp[i];
  end
endmodule

// File: rtl/mul_sched.sv
// Two-requester round-robin front end sharing one Booth multiplier through an
// issue stage (S1) and a result stage (S2).
module mul_sched
  import mul_sched_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_op1,
  input  logic [XLEN-1:0] req0_op2,
  input  logic            req0_s_or_us,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_op1,
  input  logic [XLEN-1:0] req1_op2,
  input  logic            req1_s_or_us,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic            resp_id,
  output logic [PLEN-1:0] resp_product
);
  localparam int STAGES = 2;

  logic [STAGES:1]  vld_pipe;
  iss_t             s1_q;
  res_t             s2_q;
  iss_t [NREQ-1:0]  req_pkt;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  grant;
  logic             last_id;
  logic             s1_adv;
  logic             s1_free;
  logic             resp_fire;
  logic [PLEN-1:0]  product;

  assign req_valid  = {req1_valid, req0_valid};
  assign req_pkt[0] = '{op1: req0_op1, op2: req0_op2, s_or_us: req0_s_or_us, id: 1'b0};
  assign req_pkt[1] = '{op1: req1_op1, op2: req1_op2, s_or_us: req1_s_or_us, id: 1'b1};

  assign resp_fire = vld_pipe[2] && resp_ready;
  assign s1_adv    = vld_pipe[1] && (!vld_pipe[2] || resp_ready);
  assign s1_free   = !vld_pipe[1] || s1_adv;

  // Tie goes to the requester that did not win the previous handshake.
  always_comb begin
    grant = '0;
    if (s1_free && !rst) begin
      if (&req_valid) grant = last_id ? 2'b01 : 2'b10;
      else            grant = req_valid;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      last_id  <= 1'b1;
    end else begin
      if (|grant) begin
        vld_pipe[1] <= 1'b1;
        s1_q        <= grant[1] ? req_pkt[1] : req_pkt[0];
        last_id     <= grant[1];
      end else if (s1_adv) begin
        vld_pipe[1] <= 1'b0;
      end
      // A refill on the draining edge keeps S2 full with no bubble.
      if (s1_adv) begin
        vld_pipe[2] <= 1'b1;
        s2_q        <= '{product: product, id: s1_q.id};
      end else if (resp_fire) begin
        vld_pipe[2] <= 1'b0;
      end
    end
  end

  booth_multiplier u_mul (
    .op1     (s1_q.op1),
    .op2     (s1_q.op2),
    .s_or_us (s1_q.s_or_us),
    .product (product)
  );

  assign resp_valid   = vld_pipe[2];
  assign resp_id      = s2_q.id;
  assign resp_product = s2_q.product;
endmodule

// File: tb/tb_mul_sched.sv
// Self-checking bench: directed scenarios plus a randomized run against a
// queue-based ordering/latency/arbitration model.
module tb_mul_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v [2];
  logic [31:0] a [2];
  logic [31:0] b [2];
  logic        s [2];
  logic        r0, r1;
  logic        resp_valid, resp_ready, resp_id;
  logic [63:0] resp_product;

  int   n_cmp = 0, n_err = 0, cyc = 0;
  int   n_acc = 0, n_resp = 0;
  logic mon_en = 1'b0;
  logic last_g = 1'b1;

  typedef struct {
    logic        id;
    logic [63:0] prod;
    int          edge_n;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_sched dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (v[0]),
    .req0_ready   (r0),
    .req0_op1     (a[0]),
    .req0_op2     (b[0]),
    .req0_s_or_us (s[0]),
    .req1_valid   (v[1]),
    .req1_ready   (r1),
    .req1_op1     (a[1]),
    .req1_op2     (b[1]),
    .req1_s_or_us (s[1]),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_id      (resp_id),
    .resp_product (resp_product)
  );

  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                          input logic sg);
    longint          sx, sy;
    longint unsigned ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'(x);
    uy = longint'(y);
    if (sg) return 64'(sx * sy);
    return 64'(ux * uy);
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: results leave in acceptance order, visible one edge after the
  // accepting edge; S1+S2 hold at most two; ties go to the non-last winner.
  always @(negedge clk) begin
    logic       exp_rv, can_acc;
    logic [1:0] exp_g;
    exp_t       e;
    if (mon_en && !rst) begin
      exp_rv = (q.size() > 0) && (q[0].edge_n + 1 <= cyc);
      n_cmp++;
      if (resp_valid !== exp_rv) begin
        n_err++;
        $display("FAIL mon_resp_valid cyc=%0d got=%b exp=%b", cyc, resp_valid, exp_rv);
      end
      if (exp_rv && resp_valid === 1'b1) begin
        n_cmp++;
        if (resp_id !== q[0].id || resp_product !== q[0].prod) begin
          n_err++;
          $display("FAIL mon_resp_data cyc=%0d got=%0d/%h exp=%0d/%h",
                   cyc, resp_id, resp_product, q[0].id, q[0].prod);
        end
      end
      can_acc = (q.size() < 2) || (exp_rv && resp_ready);
      exp_g = 2'b00;
      if (can_acc) begin
        if (v[0] && v[1]) exp_g = last_g ? 2'b01 : 2'b10;
        else              exp_g = {v[1], v[0]};
      end
      n_cmp++;
      if ({r1, r0} !== exp_g) begin
        n_err++;
        $display("FAIL mon_grant cyc=%0d got=%b exp=%b", cyc, {r1, r0}, exp_g);
      end
      if (resp_valid && resp_ready) n_resp++;
      if (exp_rv && resp_ready) e = q.pop_front();
      for (int i = 0; i < 2; i++) begin
        if (v[i] && ((i == 0) ? r0 : r1)) begin
          e.id = (i == 1);
          e.prod = ref_mul(a[i], b[i], s[i]);
          e.edge_n = cyc + 1;
          q.push_back(e);
          last_g = (i == 1);
          n_acc++;
        end
      end
    end
  end

  task automatic test_reset();
    v[0] = 1'b1; v[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (r0 !== 1'b0 || r1 !== 1'b0) begin n_err++; $display("FAIL rst_ready got=%b%b exp=00", r1, r0); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    n_cmp++; if (resp_id !== 1'b0) begin n_err++; $display("FAIL rst_resp_id got=%b exp=0", resp_id); end
    n_cmp++; if (resp_product !== 64'h0) begin n_err++; $display("FAIL rst_resp_product got=%h exp=0", resp_product); end
    v[0] = 1'b0; v[1] = 1'b0;
    rst = 1'b0;
    q.delete();
    last_g = 1'b1;
    mon_en = 1'b1;
    tick();
  endtask

  task automatic test_vectors();
    int          vid [3] = '{0, 1, 1};
    logic [31:0] va  [3] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] vb  [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic        vs  [3] = '{1'b0, 1'b1, 1'b0};
    logic [63:0] vp  [3] = '{64'hFFFF_FFFE_0000_0001, 64'h0000_0000_8000_0000,
                             64'h7FFF_FFFF_8000_0000};
    resp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int id = vid[k];
      v[id] = 1'b1; a[id] = va[k]; b[id] = vb[k]; s[id] = vs[k];
      @(negedge clk);
      n_cmp++; if (((id == 1) ? r1 : r0) !== 1'b1) begin n_err++; $display("FAIL vec%0d_ready got=0 exp=1", k); end
      @(posedge clk); #1;
      v[id] = 1'b0;
      @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL vec%0d_early got=%b exp=0", k, resp_valid); end
      @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b1) begin n_err++; $display("FAIL vec%0d_valid got=%b exp=1", k, resp_valid); end
      n_cmp++; if (resp_id !== 1'(id)) begin n_err++; $display("FAIL vec%0d_id got=%0d exp=%0d", k, resp_id, id); end
      n_cmp++; if (resp_product !== vp[k]) begin n_err++; $display("FAIL vec%0d_product got=%h exp=%h", k, resp_product, vp[k]); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic exp_id;
    resp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      a[i] = $urandom; b[i] = $urandom; s[i] = 1'($urandom_range(1)); v[i] = 1'b1;
    end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c < 6) begin
        n_cmp++;
        if ({r1, r0} !== ((c % 2 == 1) ? 2'b10 : 2'b01)) begin
          n_err++; $display("FAIL b2b_grant c=%0d got=%b", c, {r1, r0});
        end
      end
      if (c >= 2) begin
        exp_id = ((c - 2) % 2 == 1);
        n_cmp++;
        if (resp_valid !== 1'b1 || resp_id !== exp_id) begin
          n_err++; $display("FAIL b2b_resp c=%0d got=%b/%b exp=1/%b", c, resp_valid, resp_id, exp_id);
        end
      end
      @(posedge clk);
      if (c == 5) begin #1; v[0] = 1'b0; v[1] = 1'b0; end
    end
    #1;
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL b2b_tail got=%b exp=0", resp_valid); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] oa [3], ob [3];
    logic        os [3];
    logic [63:0] op [3];
    for (int k = 0; k < 3; k++) begin
      oa[k] = pick(); ob[k] = pick(); os[k] = 1'($urandom_range(1));
      op[k] = ref_mul(oa[k], ob[k], os[k]);
    end
    resp_ready = 1'b0;
    v[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      v[0] = 1'b1; a[0] = oa[k]; b[0] = ob[k]; s[0] = os[k];
      @(negedge clk);
      n_cmp++; if (r0 !== 1'b1) begin n_err++; $display("FAIL bp_accept%0d got=%b exp=1", k, r0); end
      tick();
    end
    a[0] = oa[2]; b[0] = ob[2]; s[0] = os[2];
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if (r0 !== 1'b0) begin n_err++; $display("FAIL bp_block%0d got=%b exp=0", k, r0); end
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_product !== op[0]) begin
        n_err++; $display("FAIL bp_hold%0d got=%b/%h exp=1/%h", k, resp_valid, resp_product, op[0]);
      end
      tick();
    end
    resp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (r0 !== 1'b1) begin n_err++; $display("FAIL bp_third got=%b exp=1", r0); end
    n_cmp++; if (resp_product !== op[0]) begin n_err++; $display("FAIL bp_drain0 got=%h exp=%h", resp_product, op[0]); end
    @(posedge clk); #1;
    v[0] = 1'b0;
    for (int k = 1; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_product !== op[k]) begin
        n_err++; $display("FAIL bp_drain%0d got=%b/%h exp=1/%h", k, resp_valid, resp_product, op[k]);
      end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL bp_empty got=%b exp=0", resp_valid); end
    tick();
  endtask

  task automatic test_random();
    logic hs [2];
    int   acc0, resp0;
    acc0 = n_acc; resp0 = n_resp;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      hs[0] = v[0] && r0;
      hs[1] = v[1] && r1;
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        // Held requests keep their payload; occasionally one is withdrawn.
        if (!(v[i] && !hs[i] && $urandom_range(7) != 0)) begin
          v[i] = ($urandom_range(2) != 0);
          a[i] = pick(); b[i] = pick(); s[i] = 1'($urandom_range(1));
        end
      end
      resp_ready = ($urandom_range(3) != 0);
    end
    v[0] = 1'b0; v[1] = 1'b0; resp_ready = 1'b1;
    repeat (6) tick();
    @(negedge clk);
    n_cmp++;
    if ((n_resp - resp0) !== (n_acc - acc0)) begin
      n_err++; $display("FAIL rand_count got=%0d exp=%0d", n_resp - resp0, n_acc - acc0);
    end
    tick();
  endtask

  task automatic test_reset_inflight();
    resp_ready = 1'b0;
    v[0] = 1'b1; a[0] = pick(); b[0] = pick(); s[0] = 1'b1;
    tick();
    a[0] = pick(); b[0] = pick();
    tick();
    v[1] = 1'b1; a[1] = pick(); b[1] = pick(); s[1] = 1'b0;
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b1 || {r1, r0} !== 2'b00) begin n_err++; $display("FAIL rif_full got=%b/%b%b exp=1/00", resp_valid, r1, r0); end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rif_async_valid got=%b exp=0", resp_valid); end
    n_cmp++; if ({r1, r0} !== 2'b00) begin n_err++; $display("FAIL rif_async_ready got=%b%b exp=00", r1, r0); end
    n_cmp++; if (resp_product !== 64'h0 || resp_id !== 1'b0) begin n_err++; $display("FAIL rif_async_data got=%0d/%h exp=0/0", resp_id, resp_product); end
    q.delete();
    last_g = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({r1, r0} !== 2'b01) begin n_err++; $display("FAIL rif_tie got=%b%b exp=01", r1, r0); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rif_stale0 got=%b exp=0", resp_valid); end
    @(posedge clk); #1;
    v[0] = 1'b0;
    @(negedge clk);
    n_cmp++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL rif_stale1 got=%b exp=0", resp_valid); end
    tick();
    v[1] = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; a[i] = '0; b[i] = '0; s[i] = 1'b0;
    end
    resp_ready = 1'b0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
